mem_arbiter: RTL and testbench

Single-port memory arbiter sitting directly downstream of the core's two memory ports. Accepts the instruction-fetch read request and the data load/store request, grants one at a time to a shared single-port memory via a req/ack handshake, and returns a one-cycle valid pulse plus read data to the requesting port. Data requests have priority; a starvation counter bounds instruction-fetch waiting time, and a timeout counter bounds memory waiting time.

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store.
// Data has priority; a starvation counter bounds how long a fetch waits.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W/8-1:0] inst_mask,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we_re,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W/8-1:0] data_mask,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  localparam int MW = DATA_W / 8;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
  localparam logic [SW-1:0] ST_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    INST_BUSY,
    DATA_BUSY
  } state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [MW-1:0]     mem_mask_q;
  logic              inst_valid_q;
  logic              data_valid_q;
  logic [DATA_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;
  logic              bus_err_q;
  logic [TW-1:0]     tmo_q;
  logic [SW-1:0]     starve_q;
  logic [SW-1:0]     starve_d;

  logic inst_elig;
  logic data_elig;
  logic starved;
  logic idle;
  logic grant_d;
  logic grant_i;

  // A requester whose valid is high is still holding its finished request.
  // A held data request shadowed by its own valid still outranks fetch,
  // so back-to-back data traffic only yields once the fetch is starved.
  always_comb begin
    inst_elig = inst_req & ~inst_valid_q;
    data_elig = data_req & ~data_valid_q;
    starved   = (starve_q == ST_MAX);
    idle      = (state_q == IDLE);
    grant_d   = idle & data_elig & (~inst_elig | ~starved);
    grant_i   = idle & ~grant_d & inst_elig & (~data_req | starved);
  end

  // Starvation count: data grants taken while a fetch is pending.
  always_comb begin
    starve_d = starve_q;
    if (!inst_req) begin
      starve_d = '0;
    end else if (grant_i) begin
      starve_d = '0;
    end else if (grant_d && !starved) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Arbitration FSM with registered memory-side and completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_mask_q   <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      bus_err_q    <= 1'b0;
      tmo_q        <= '0;
      starve_q     <= '0;
    end else begin
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      starve_q     <= starve_d;
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= DATA_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= data_we_re;
            mem_addr_q  <= data_addr;
            mem_wdata_q <= data_wdata;
            mem_mask_q  <= data_mask;
            tmo_q       <= '0;
          end else if (grant_i) begin
            state_q     <= INST_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= inst_addr;
            mem_wdata_q <= '0;
            mem_mask_q  <= inst_mask;
            tmo_q       <= '0;
          end
        end
        INST_BUSY, DATA_BUSY: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            if (state_q == INST_BUSY) begin
              inst_valid_q <= 1'b1;
              inst_rdata_q <= mem_rdata;
            end else begin
              data_valid_q <= 1'b1;
              data_rdata_q <= mem_we_q ? '0 : mem_rdata;
            end
          end else if (tmo_q == TO_MAX) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            if (state_q == INST_BUSY) begin
              inst_valid_q <= 1'b1;
              inst_rdata_q <= '0;
            end else begin
              data_valid_q <= 1'b1;
              data_rdata_q <= '0;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_mask   = mem_mask_q;
  assign inst_valid = inst_valid_q;
  assign inst_rdata = inst_rdata_q;
  assign data_valid = data_valid_q;
  assign data_rdata = data_rdata_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a
// latency-programmable memory responder.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [3:0]  inst_mask;
  logic        inst_valid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_we_re;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_mask;
  logic        data_valid;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int errs = 0;
  int checks = 0;

  logic        auto_ack = 1'b0;
  int          ack_dly = 0;
  int          wcnt = 0;
  logic [31:0] memm [0:255];
  logic [31:0] expm [0:255];

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_mask(inst_mask), .inst_valid(inst_valid),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we_re(data_we_re),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_mask(data_mask), .data_valid(data_valid),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Memory responder: acks ack_dly cycles after mem_req rises.
  initial begin
    logic [31:0] t;
    forever begin
      @(posedge clk);
      #1;
      if (auto_ack) begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (wcnt >= ack_dly) begin
            mem_ack = 1'b1;
            wcnt = 0;
            if (mem_we) begin
              t = memm[mem_addr[9:2]];
              for (int b = 0; b < 4; b++)
                if (mem_mask[b]) t[8*b +: 8] = mem_wdata[8*b +: 8];
              memm[mem_addr[9:2]] = t;
              mem_rdata = 32'hBAD0_0000;
            end else begin
              mem_rdata = memm[mem_addr[9:2]];
            end
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input bit is_inst, input string tag);
    int n = 0;
    while (((is_inst ? inst_valid : data_valid) !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bound"}, 32'(n < 40), 32'd1);
  endtask

  task automatic do_req(input bit is_inst, input bit we,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, input logic [31:0] exp_rd,
                        input string tag);
    if (is_inst) begin
      inst_addr = a; inst_mask = m; inst_req = 1'b1;
    end else begin
      data_addr = a; data_we_re = we; data_wdata = wd;
      data_mask = m; data_req = 1'b1;
    end
    wait_valid(is_inst, tag);
    chk({tag, "_rdata"}, is_inst ? inst_rdata : data_rdata, exp_rd);
    chk({tag, "_berr"}, 32'(bus_err), 32'd0);
    inst_req = 1'b0;
    data_req = 1'b0;
    @(negedge clk);
    chk({tag, "_once"}, 32'(inst_valid | data_valid), 32'd0);
  endtask

  initial begin
    logic [9:0]  pat;
    logic [9:0]  got;
    logic        prev;
    int          g, n, cnt;
    bit          ri, rw;
    logic [7:0]  ix;
    logic [31:0] wd, er, t;
    logic [3:0]  m;

    rst = 1'b1;
    inst_req = 0; inst_addr = 0; inst_mask = 0;
    data_req = 0; data_we_re = 0; data_addr = 0;
    data_wdata = 32'hFFFF_FFFF; data_mask = 0;
    mem_ack = 0; mem_rdata = 0;
    for (int i = 0; i < 256; i++) begin
      memm[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
      expm[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    end
    memm[64] = 32'h0050_0093;
    expm[64] = 32'h0050_0093;

    #2;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    auto_ack = 1'b1;
    ack_dly = 0;
    @(negedge clk);

    inst_addr = 32'h100; inst_mask = 4'hF; inst_req = 1'b1;
    @(negedge clk);
    chk("f_mem_req", 32'(mem_req), 1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we", 32'(mem_we), 0);
    chk("f_mem_wdata", mem_wdata, 0);
    chk("f_early_valid", 32'(inst_valid), 0);
    @(negedge clk);
    chk("f_valid", 32'(inst_valid), 1);
    chk("f_rdata", inst_rdata, 32'h0050_0093);
    chk("f_req_drop", 32'(mem_req), 0);
    inst_req = 1'b0;
    @(negedge clk);
    chk("f_pulse", 32'(inst_valid), 0);
    chk("f_hold", inst_rdata, 32'h0050_0093);

    ack_dly = 1;
    data_we_re = 1'b1; data_addr = 32'h200;
    data_wdata = 32'hDEAD_BEEF; data_mask = 4'hF; data_req = 1'b1;
    @(negedge clk);
    chk("st_mem_req", 32'(mem_req), 1);
    chk("st_mem_we", 32'(mem_we), 1);
    chk("st_mem_addr", mem_addr, 32'h200);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_mem_mask", 32'(mem_mask), 32'hF);
    wait_valid(1'b0, "st");
    chk("st_rdata", data_rdata, 0);
    @(negedge clk);
    chk("st_nodup", 32'(mem_req), 0);
    chk("st_pulse", 32'(data_valid), 0);
    data_we_re = 1'b0; data_wdata = 0;
    @(negedge clk);
    chk("ld_mem_req", 32'(mem_req), 1);
    chk("ld_mem_we", 32'(mem_we), 0);
    wait_valid(1'b0, "ld");
    chk("ld_rdata", data_rdata, 32'hDEAD_BEEF);
    data_req = 1'b0;
    @(negedge clk);
    chk("ld_pulse", 32'(data_valid), 0);

    ack_dly = 0;
    data_addr = 32'h300; data_we_re = 1'b0;
    inst_addr = 32'h100;
    inst_req = 1'b1; data_req = 1'b1;
    pat = 10'b01111_01111;
    got = '0; g = 0; n = 0; prev = 1'b0;
    while (g < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (mem_req && !prev) begin
        got[g] = (mem_addr == 32'h300);
        g++;
      end
      prev = mem_req;
    end
    chk("cont_bound", 32'(g), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("cont_grant%0d", i), 32'(got[i]), 32'(pat[i]));
    @(negedge clk);
    chk("cont_last_valid", 32'(inst_valid), 1);
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    chk("cont_idle", 32'(mem_req), 0);

    auto_ack = 1'b0; mem_ack = 1'b0;
    data_addr = 32'h40; data_we_re = 1'b0; data_req = 1'b1;
    n = 0; cnt = 0;
    while (data_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_req) cnt++;
    end
    chk("to_req_cycles", 32'(cnt), 9);
    chk("to_valid", 32'(data_valid), 1);
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_rdata", data_rdata, 0);
    data_req = 1'b0;
    @(negedge clk);
    chk("to_err_pulse", 32'(bus_err), 0);
    chk("to_valid_pulse", 32'(data_valid), 0);
    auto_ack = 1'b1;
    do_req(1'b1, 1'b0, 32'h100, 0, 4'hF, 32'h0050_0093, "post_to");

    auto_ack = 1'b0; mem_ack = 1'b0;
    data_addr = 32'h280; data_we_re = 1'b1;
    data_wdata = 32'h1234_5678; data_mask = 4'hF; data_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rm_busy", 32'(mem_req), 1);
    rst = 1'b1;
    #1;
    chk("rm_mem_req", 32'(mem_req), 0);
    chk("rm_mem_we", 32'(mem_we), 0);
    chk("rm_mem_addr", mem_addr, 0);
    chk("rm_mem_wdata", mem_wdata, 0);
    chk("rm_inst_rdata", inst_rdata, 0);
    data_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rm_late_ack_req", 32'(mem_req), 0);
    chk("rm_late_ack_valid", 32'(data_valid | inst_valid), 0);
    @(negedge clk);
    chk("rm_no_valid", 32'(data_valid | inst_valid), 0);

    auto_ack = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ri = 1'($urandom_range(0, 1));
      rw = !ri && ($urandom_range(0, 1) == 1);
      ix = 8'(60 + $urandom_range(0, 15));
      wd = $urandom;
      m = 4'($urandom_range(1, 15));
      ack_dly = $urandom_range(0, 5);
      if (rw) begin
        er = 0;
        t = expm[ix];
        for (int b = 0; b < 4; b++)
          if (m[b]) t[8*b +: 8] = wd[8*b +: 8];
        expm[ix] = t;
      end else begin
        er = expm[ix];
      end
      do_req(ri, rw, {22'd0, ix, 2'b00}, wd, m, er,
             $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
